// File: rtl/config_stream_loader_pkg.sv
// Shared constants, entry field layout and state encoding for the config stream loader.
package config_stream_loader_pkg;

   localparam int DATA_WIDTH_DEF     = 32;
   localparam int TGT_W_DEF          = 5;
   localparam int TBL_AW_DEF         = 6;
   localparam int TIMEOUT_CYCLES_DEF = 1024;

   // Table entry is {target, value}: value in the low bits, target directly above it.
   localparam int VAL_LSB = 0;
   localparam int TGT_LSB = VAL_LSB + DATA_WIDTH_DEF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DATA   = 3'd3,
      ST_FINISH = 3'd4
   } cfg_state_e;

   // Bits needed to hold n-1, the load value of an n-cycle wait window.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/config_stream_loader_timeout.sv
// Loadable down-counter bounding the wait for an address-beat handshake.
module cfg_timeout_counter #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/config_stream_loader.sv
// Streams {target, value} table entries as address-beat / data-beat pairs on the config channel.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | table read data returning; captures entry, loads timeout
// ADDR   | address beat held until handshake or timeout
// DATA   | data beat, exactly one cycle, ready ignored
// FINISH | one-cycle done pulse
module config_stream_loader
   import config_stream_loader_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int TGT_W          = TGT_W_DEF,
   parameter int TBL_AW         = TBL_AW_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [TBL_AW-1:0]       base,
   input  logic [TBL_AW:0]         count,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [TBL_AW:0]         sent_cnt,
   output logic                    tbl_rd_en,
   output logic [TBL_AW-1:0]       tbl_rd_addr,
   input  logic [TGT_W+DATA_WIDTH-1:0] tbl_rd_data,
   output logic [DATA_WIDTH-1:0]   cfg_data,
   output logic                    cfg_valid,
   input  logic                    cfg_ready
);

   localparam int ENT_VAL_LSB = VAL_LSB;
   localparam int ENT_TGT_LSB = VAL_LSB + DATA_WIDTH;
   localparam int TMR_W       = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   cfg_state_e              state_q, state_d;
   logic [TBL_AW-1:0]       idx_q, idx_d;
   logic [TBL_AW:0]         count_q, count_d;
   logic [TBL_AW:0]         sent_q, sent_d;
   logic                    err_q, err_d;
   logic [TGT_W-1:0]        tgt_q, tgt_d;
   logic [DATA_WIDTH-1:0]   val_q, val_d;
   logic [TBL_AW:0]         sent_inc;
   logic [TBL_AW-1:0]       idx_inc;
   logic                    tmr_load;
   logic                    tmr_dec;
   logic                    tmr_expired;

   cfg_timeout_counter #(
      .CNT_W (TMR_W)
   ) u_timeout (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (TMR_LOAD),
      .dec_i      (tmr_dec),
      .expired_o  (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      count_d     = count_q;
      sent_d      = sent_q;
      err_d       = err_q;
      tgt_d       = tgt_q;
      val_d       = val_q;
      sent_inc    = sent_q + 1'b1;
      idx_inc     = idx_q + 1'b1;
      tmr_load    = 1'b0;
      tmr_dec     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      tbl_rd_en   = 1'b0;
      tbl_rd_addr = '0;
      cfg_valid   = 1'b0;
      cfg_data    = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               err_d  = 1'b0;
               sent_d = '0;
               if (count == '0) begin
                  state_d = ST_FINISH;
               end else begin
                  idx_d       = base;
                  count_d     = count;
                  tbl_rd_en   = 1'b1;
                  tbl_rd_addr = base;
                  state_d     = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            busy     = 1'b1;
            tgt_d    = tbl_rd_data[ENT_TGT_LSB +: TGT_W];
            val_d    = tbl_rd_data[ENT_VAL_LSB +: DATA_WIDTH];
            tmr_load = 1'b1;
            state_d  = ST_ADDR;
         end
         ST_ADDR: begin
            busy                = 1'b1;
            cfg_valid           = 1'b1;
            cfg_data[TGT_W-1:0] = tgt_q;
            if (cfg_ready) begin
               state_d = ST_DATA;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_DATA: begin
            // The receiver samples the data beat unconditionally; cfg_ready is don't-care here.
            busy      = 1'b1;
            cfg_valid = 1'b1;
            cfg_data  = val_q;
            sent_d    = sent_inc;
            if (sent_inc == count_q) begin
               state_d = ST_FINISH;
            end else begin
               idx_d       = idx_inc;
               tbl_rd_en   = 1'b1;
               tbl_rd_addr = idx_inc;
               state_d     = ST_FETCH;
            end
         end
         ST_FINISH: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         count_q <= '0;
         sent_q  <= '0;
         err_q   <= 1'b0;
         tgt_q   <= '0;
         val_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         sent_q  <= sent_d;
         err_q   <= err_d;
         tgt_q   <= tgt_d;
         val_q   <= val_d;
      end
   end

   assign error    = err_q;
   assign sent_cnt = sent_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench: table-driven sequences against a receiver model, plus reset and busy-start corners.
module tb_config_stream_loader;

   localparam int DW  = 32;
   localparam int TW  = 5;
   localparam int AW  = 6;
   localparam int TMO = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [AW-1:0]     base = '0;
   logic [AW:0]       count = '0;
   logic              busy, done, error;
   logic [AW:0]       sent_cnt;
   logic              tbl_rd_en;
   logic [AW-1:0]     tbl_rd_addr;
   logic [TW+DW-1:0]  tbl_rd_data = '0;
   logic [DW-1:0]     cfg_data;
   logic              cfg_valid;
   logic              cfg_ready = 1'b0;

   config_stream_loader #(
      .DATA_WIDTH     (DW),
      .TGT_W          (TW),
      .TBL_AW         (AW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base        (base),
      .count       (count),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .sent_cnt    (sent_cnt),
      .tbl_rd_en   (tbl_rd_en),
      .tbl_rd_addr (tbl_rd_addr),
      .tbl_rd_data (tbl_rd_data),
      .cfg_data    (cfg_data),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready)
   );

   always #5 clk = ~clk;

   // Local config table with one-cycle read latency.
   logic [TW+DW-1:0] tbl [64];
   always @(posedge clk) begin
      if (tbl_rd_en) tbl_rd_data <= tbl[tbl_rd_addr];
   end

   typedef struct {
      logic [DW-1:0] addr_beat;
      logic [DW-1:0] val;
      int            addr_cyc;
      int            data_cyc;
   } wr_t;

   wr_t wr_q[$];
   int  rd_q[$];
   int  done_cyc[$];
   int  valid_cycles;
   int  proto_err;
   int  cyc = 0;
   int  rdy_mode = 0;   // 0: always ready, 1: not ready the cycle after a data beat, 2: never ready
   int  start_cyc;
   int  checks = 0;
   int  failures = 0;

   // Receiver model and event logger, evaluated mid-cycle.
   logic          rcv_in_data = 1'b0;
   logic          prev_data = 1'b0;
   logic [DW-1:0] pend_addr;
   int            pend_cyc;
   always @(negedge clk) begin
      wr_t w;
      logic now_data;
      cyc++;
      if (!rst_n) begin
         rcv_in_data = 1'b0;
         prev_data   = 1'b0;
      end else begin
         cfg_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? !prev_data : 1'b0;
         now_data  = 1'b0;
         if (tbl_rd_en) rd_q.push_back(int'(tbl_rd_addr));
         if (cfg_valid) valid_cycles++;
         if (done) done_cyc.push_back(cyc);
         if (rcv_in_data) begin
            if (cfg_valid) begin
               w.addr_beat = pend_addr;
               w.val       = cfg_data;
               w.addr_cyc  = pend_cyc;
               w.data_cyc  = cyc;
               wr_q.push_back(w);
            end else begin
               proto_err++;
            end
            rcv_in_data = 1'b0;
            now_data    = 1'b1;
         end else if (cfg_valid && cfg_ready) begin
            pend_addr   = cfg_data;
            pend_cyc    = cyc;
            rcv_in_data = 1'b1;
         end
         prev_data = now_data;
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      wr_q.delete();
      rd_q.delete();
      done_cyc.delete();
      valid_cycles = 0;
      proto_err    = 0;
   endtask

   task automatic pulse_start(input int b, input int c);
      @(posedge clk); #1;
      base      = AW'(b);
      count     = (AW+1)'(c);
      start     = 1'b1;
      start_cyc = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cyc.size() == 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_seen", done_cyc.size(), 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic longint all_outs();
      return {busy, done, error, sent_cnt, tbl_rd_en, tbl_rd_addr, cfg_valid, cfg_data};
   endfunction

   typedef struct {
      int base;
      int count;
      int mode;
      int exp_sent;    // -1: not compared
      int exp_err;
      int exp_cycles;  // start cycle to done cycle
   } vec_t;

   vec_t vecs[7];

   initial begin
      int nrd, nwr, idx;
      for (int i = 0; i < 64; i++) begin
         tbl[i] = {TW'(i * 7 + 3), 32'hC0DE0000 + 32'(i * 257)};
      end
      tbl[20] = {5'd5, 32'hDEADBEEF};

      vecs[0] = '{20, 1,  0, 1,  0, 4};
      vecs[1] = '{0,  3,  1, 3,  0, 10};
      vecs[2] = '{62, 4,  1, 4,  0, 13};
      vecs[3] = '{5,  0,  0, -1, 0, 1};
      vecs[4] = '{7,  2,  2, 0,  1, 10};
      vecs[5] = '{9,  2,  0, 2,  0, 7};
      vecs[6] = '{63, 64, 0, 64, 0, 193};

      #1;
      chk("reset_outputs", all_outs(), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_outputs", all_outs(), 0);

      for (int v = 0; v < 7; v++) begin
         clear_logs();
         rdy_mode = vecs[v].mode;
         pulse_start(vecs[v].base, vecs[v].count);
         wait_done(400);
         if (done_cyc.size() > 0) chk("done_latency", done_cyc[0] - start_cyc, vecs[v].exp_cycles);
         if (vecs[v].exp_sent >= 0) chk("sent_cnt", sent_cnt, vecs[v].exp_sent);
         chk("error", error, vecs[v].exp_err);
         chk("busy_after", busy, 0);
         nrd = (vecs[v].exp_err != 0) ? vecs[v].exp_sent + 1 : vecs[v].count;
         nwr = (vecs[v].exp_err != 0) ? 0 : vecs[v].count;
         chk("n_reads", rd_q.size(), nrd);
         for (int k = 0; k < rd_q.size() && k < nrd; k++) begin
            chk("rd_addr", rd_q[k], (vecs[v].base + k) % 64);
         end
         chk("n_writes", wr_q.size(), nwr);
         for (int k = 0; k < wr_q.size() && k < nwr; k++) begin
            idx = (vecs[v].base + k) % 64;
            chk("addr_beat", wr_q[k].addr_beat, {27'd0, tbl[idx][DW +: TW]});
            chk("data_beat", wr_q[k].val, tbl[idx][DW-1:0]);
            chk("addr_to_data", wr_q[k].data_cyc - wr_q[k].addr_cyc, 1);
            if (k > 0) chk("pair_spacing", wr_q[k].data_cyc - wr_q[k-1].data_cyc, 3);
         end
         chk("valid_cycles", valid_cycles, (vecs[v].exp_err != 0) ? TMO : 2 * vecs[v].count);
         chk("proto", proto_err, 0);
      end

      // Reset asserted during the data beat abandons the transfer silently.
      clear_logs();
      rdy_mode = 0;
      pulse_start(20, 1);
      @(posedge clk); #1;
      chk("rst_addr_beat", {cfg_valid, cfg_data}, {1'b1, 32'h00000005});
      @(posedge clk); #1;
      chk("rst_data_beat", {busy, cfg_valid, cfg_data}, {2'b11, 32'hDEADBEEF});
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", all_outs(), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_no_done", done_cyc.size(), 0);
      chk("rst_no_write", wr_q.size(), 0);
      chk("rst_idle", all_outs(), 0);

      // Start while busy is ignored.
      clear_logs();
      rdy_mode = 1;
      pulse_start(30, 3);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_mid", busy, 1);
      base  = 6'd0;
      count = 7'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(100);
      chk("ign_sent_cnt", sent_cnt, 3);
      chk("ign_n_writes", wr_q.size(), 3);
      chk("ign_n_reads", rd_q.size(), 3);
      for (int k = 0; k < wr_q.size() && k < 3; k++) begin
         chk("ign_rd_addr", rd_q[k], 30 + k);
         chk("ign_data_beat", wr_q[k].val, tbl[30 + k][DW-1:0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
